// File: rtl/vtg_pkg.sv
// Shared timing constants and region-decode helpers for the raster timing generator.
// Default constants describe a 480x272 LCD panel.
package vtg_pkg;

  localparam int unsigned CW_DEF       = 12;
  localparam int unsigned H_ACTIVE_DEF = 480;
  localparam int unsigned H_FP_DEF     = 8;
  localparam int unsigned H_SYNC_DEF   = 4;
  localparam int unsigned H_BP_DEF     = 43;
  localparam int unsigned V_ACTIVE_DEF = 272;
  localparam int unsigned V_FP_DEF     = 4;
  localparam int unsigned V_SYNC_DEF   = 10;
  localparam int unsigned V_BP_DEF     = 2;

  function automatic int unsigned vtg_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic in_active(input int unsigned c, input int unsigned active);
    return c < active;
  endfunction

  // Sync occupies [active+fp, active+fp+sync-1], after the front porch.
  function automatic logic in_sync(input int unsigned c,
                                   input int unsigned active,
                                   input int unsigned fp,
                                   input int unsigned sync);
    return (c >= active + fp) && (c < active + fp + sync);
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing-output bundle driven by video_timing_gen.
// VTG_LOOKAHEAD_EN adds nx_o/ny_o/nde_o describing the next enabled pixel.
interface video_timing_gen_if #(
  parameter int unsigned CW = 12
);
  logic          hsync_o;
  logic          vsync_o;
  logic          de_o;
  logic [CW-1:0] x_o;
  logic [CW-1:0] y_o;
  logic          sol_o;
  logic          sof_o;

`ifdef VTG_LOOKAHEAD_EN
  logic [CW-1:0] nx_o;
  logic [CW-1:0] ny_o;
  logic          nde_o;

  modport master (
    output hsync_o, vsync_o, de_o, x_o, y_o, sol_o, sof_o, nx_o, ny_o, nde_o
  );
  modport slave (
    input  hsync_o, vsync_o, de_o, x_o, y_o, sol_o, sof_o, nx_o, ny_o, nde_o
  );
`else
  modport master (
    output hsync_o, vsync_o, de_o, x_o, y_o, sol_o, sof_o
  );
  modport slave (
    input  hsync_o, vsync_o, de_o, x_o, y_o, sol_o, sof_o
  );
`endif

endinterface

// File: rtl/vtg_axis.sv
// Single-axis raster counter: wrap flag, next-state active decode and registered sync.
// Used for both the horizontal and the vertical axis.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int unsigned CW     = 12,
  parameter int unsigned ACTIVE = 1,
  parameter int unsigned FP     = 1,
  parameter int unsigned SYNC   = 1,
  parameter int unsigned BP     = 1,
  parameter bit          POL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active_nxt,
  output logic          sync
);

  localparam int unsigned   TOTAL = vtg_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_region
    $error("vtg_axis: every timing region must be at least one unit wide");
  end
  if (64'(TOTAL) > (64'd1 << CW)) begin : g_too_wide
    $error("vtg_axis: axis total does not fit in CW bits");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          sync_q;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_nxt = cnt_q;
    if (step) begin
      cnt_nxt = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Decodes come from cnt_nxt so they land in the same register stage as the count.
  assign active_nxt = in_active(32'(cnt_nxt), ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= LAST;
      sync_q <= ~POL;
    end else if (step) begin
      cnt_q  <= cnt_nxt;
      sync_q <= in_sync(32'(cnt_nxt), ACTIVE, FP, SYNC) ? POL : ~POL;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, syncs, data-enable and line/frame markers.
// Define VTG_LOOKAHEAD_EN to add the one-pixel-ahead nx_o/ny_o/nde_o outputs.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned HACTIVE = H_ACTIVE_DEF,
  parameter int unsigned HFP     = H_FP_DEF,
  parameter int unsigned HSYNC   = H_SYNC_DEF,
  parameter int unsigned HBP     = H_BP_DEF,
  parameter int unsigned VACTIVE = V_ACTIVE_DEF,
  parameter int unsigned VFP     = V_FP_DEF,
  parameter int unsigned VSYNC   = V_SYNC_DEF,
  parameter int unsigned VBP     = V_BP_DEF,
  parameter bit          HPOL    = 1'b0,
  parameter bit          VPOL    = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                ce_i,
  video_timing_gen_if.master  vid
);

  logic [CW-1:0] x_cnt;
  logic [CW-1:0] y_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_act_nxt;
  logic          v_act_nxt;
  logic          h_sync;
  logic          v_sync;
  logic          v_step;
  logic          de_q;
  logic          sol_q;
  logic          sof_q;

  vtg_axis #(
    .CW     (CW),
    .ACTIVE (HACTIVE),
    .FP     (HFP),
    .SYNC   (HSYNC),
    .BP     (HBP),
    .POL    (HPOL)
  ) u_h_axis (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .step       (ce_i),
    .cnt        (x_cnt),
    .wrap       (h_wrap),
    .active_nxt (h_act_nxt),
    .sync       (h_sync)
  );

  // Vertical steps on the same edge x wraps, so vsync edges align with x = 0.
  assign v_step = ce_i & h_wrap;

  vtg_axis #(
    .CW     (CW),
    .ACTIVE (VACTIVE),
    .FP     (VFP),
    .SYNC   (VSYNC),
    .BP     (VBP),
    .POL    (VPOL)
  ) u_v_axis (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .step       (v_step),
    .cnt        (y_cnt),
    .wrap       (v_wrap),
    .active_nxt (v_act_nxt),
    .sync       (v_sync)
  );

  // A wrap flag on the current count means the next count is 0 on that axis.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      de_q  <= 1'b0;
      sol_q <= 1'b0;
      sof_q <= 1'b0;
    end else if (ce_i) begin
      de_q  <= h_act_nxt & v_act_nxt;
      sol_q <= h_wrap;
      sof_q <= h_wrap & v_wrap;
    end
  end

  assign vid.hsync_o = h_sync;
  assign vid.vsync_o = v_sync;
  assign vid.de_o    = de_q;
  assign vid.x_o     = x_cnt;
  assign vid.y_o     = y_cnt;
  assign vid.sol_o   = sol_q;
  assign vid.sof_o   = sof_q;

`ifdef VTG_LOOKAHEAD_EN
  localparam logic [CW-1:0] H_LAST = CW'(vtg_total(HACTIVE, HFP, HSYNC, HBP) - 1);
  localparam logic [CW-1:0] V_LAST = CW'(vtg_total(VACTIVE, VFP, VSYNC, VBP) - 1);

  logic [CW-1:0] nx_q;
  logic [CW-1:0] ny_q;
  logic [CW-1:0] nx_nxt;
  logic [CW-1:0] ny_nxt;
  logic          nde_q;

  // Independent counter pair running one enabled pixel ahead; reset = pixel (0,0).
  always_comb begin
    nx_nxt = (nx_q == H_LAST) ? '0 : nx_q + 1'b1;
    ny_nxt = ny_q;
    if (nx_q == H_LAST) begin
      ny_nxt = (ny_q == V_LAST) ? '0 : ny_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      nx_q  <= '0;
      ny_q  <= '0;
      nde_q <= 1'b1;
    end else if (ce_i) begin
      nx_q  <= nx_nxt;
      ny_q  <= ny_nxt;
      nde_q <= in_active(32'(nx_nxt), HACTIVE) && in_active(32'(ny_nxt), VACTIVE);
    end
  end

  assign vid.nx_o  = nx_q;
  assign vid.ny_o  = ny_q;
  assign vid.nde_o = nde_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 480x272 instance (reset, lines, mid-frame reset) and a
// small inverted-polarity instance with ce toggled 1-of-3 over two frames.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  logic ce_a;
  logic ce_b;

  int n_vec = 0;
  int n_err = 0;

  // Expected pixel positions of each instance.
  int ax, ay, bx, by;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(12)) vid_a ();
  video_timing_gen_if #(.CW(5))  vid_b ();

  video_timing_gen u_a (
    .clk_i   (clk),
    .rst_n_i (rst_a_n),
    .ce_i    (ce_a),
    .vid     (vid_a)
  );

  // HTOTAL = 4+1+2+1 = 8, VTOTAL = 3+1+2+1 = 7, 56 pixels per frame.
  video_timing_gen #(
    .CW      (5),
    .HACTIVE (4),
    .HFP     (1),
    .HSYNC   (2),
    .HBP     (1),
    .VACTIVE (3),
    .VFP     (1),
    .VSYNC   (2),
    .VBP     (1),
    .HPOL    (1'b1),
    .VPOL    (1'b1)
  ) u_b (
    .clk_i   (clk),
    .rst_n_i (rst_b_n),
    .ce_i    (ce_b),
    .vid     (vid_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic a_adv();
    if (ax == 534) begin
      ax = 0;
      ay = (ay == 287) ? 0 : ay + 1;
    end else begin
      ax = ax + 1;
    end
  endtask

  task automatic b_adv();
    if (bx == 7) begin
      bx = 0;
      by = (by == 6) ? 0 : by + 1;
    end else begin
      bx = bx + 1;
    end
  endtask

  task automatic check_a();
    check("a_x",     32'(vid_a.x_o),     32'(ax));
    check("a_y",     32'(vid_a.y_o),     32'(ay));
    check("a_de",    32'(vid_a.de_o),    (ax < 480 && ay < 272) ? 1 : 0);
    check("a_hsync", 32'(vid_a.hsync_o), (ax >= 488 && ax <= 491) ? 0 : 1);
    check("a_vsync", 32'(vid_a.vsync_o), (ay >= 276 && ay <= 285) ? 0 : 1);
    check("a_sol",   32'(vid_a.sol_o),   (ax == 0) ? 1 : 0);
    check("a_sof",   32'(vid_a.sof_o),   (ax == 0 && ay == 0) ? 1 : 0);
`ifdef VTG_LOOKAHEAD_EN
    begin
      int enx, eny;
      enx = (ax == 534) ? 0 : ax + 1;
      eny = (ax == 534) ? ((ay == 287) ? 0 : ay + 1) : ay;
      check("a_nx",  32'(vid_a.nx_o),  32'(enx));
      check("a_ny",  32'(vid_a.ny_o),  32'(eny));
      check("a_nde", 32'(vid_a.nde_o), (enx < 480 && eny < 272) ? 1 : 0);
    end
`endif
  endtask

  task automatic check_b();
    check("b_x",     32'(vid_b.x_o),     32'(bx));
    check("b_y",     32'(vid_b.y_o),     32'(by));
    check("b_de",    32'(vid_b.de_o),    (bx < 4 && by < 3) ? 1 : 0);
    check("b_hsync", 32'(vid_b.hsync_o), (bx == 5 || bx == 6) ? 1 : 0);
    check("b_vsync", 32'(vid_b.vsync_o), (by == 4 || by == 5) ? 1 : 0);
    check("b_sol",   32'(vid_b.sol_o),   (bx == 0) ? 1 : 0);
    check("b_sof",   32'(vid_b.sof_o),   (bx == 0 && by == 0) ? 1 : 0);
`ifdef VTG_LOOKAHEAD_EN
    begin
      int enx, eny;
      enx = (bx == 7) ? 0 : bx + 1;
      eny = (bx == 7) ? ((by == 6) ? 0 : by + 1) : by;
      check("b_nx",  32'(vid_b.nx_o),  32'(enx));
      check("b_ny",  32'(vid_b.ny_o),  32'(eny));
      check("b_nde", 32'(vid_b.nde_o), (enx < 4 && eny < 3) ? 1 : 0);
    end
`endif
  endtask

  initial begin
    int hs_lo, de_n;
    int last_rise, sol_en, de_en;
    logic prev_sof, prev_vs;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ce_a    = 1'b0;
    ce_b    = 1'b0;
    ax = 534; ay = 287;
    bx = 7;   by = 6;

    // Reset state: last back-porch pixel, syncs inactive.
    repeat (3) @(posedge clk);
    #1;
    check_a();
    check_b();

    // Release with ce low: nothing moves.
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(posedge clk);
    #1;
    check_a();
    check_b();

    // Default instance, ce high, three full lines plus a few pixels.
    ce_a  = 1'b1;
    hs_lo = 0;
    de_n  = 0;
    for (int c = 0; c < 3 * 535 + 10; c++) begin
      @(posedge clk);
      a_adv();
      #1;
      check_a();
      if (vid_a.hsync_o == 1'b0) hs_lo++;
      if (vid_a.de_o == 1'b1) de_n++;
      if (ax == 534) begin
        check("a_hsync_len", 32'(hs_lo), 32'd4);
        check("a_de_len",    32'(de_n),  32'd480);
        hs_lo = 0;
        de_n  = 0;
      end
    end

    // Mid-line asynchronous reset takes effect without a clock edge.
    @(posedge clk);
    a_adv();
    #3;
    rst_a_n = 1'b0;
    #1;
    ax = 534; ay = 287;
    check_a();
    @(negedge clk);
    rst_a_n = 1'b1;
    @(posedge clk);
    a_adv();
    #1;
    check_a();
    check("a_sof_after_rst", 32'(vid_a.sof_o), 32'd1);

    // Small instance, ce high one cycle in three, a little over two frames.
    last_rise = -1;
    sol_en    = 0;
    de_en     = 0;
    prev_sof  = vid_b.sof_o;
    prev_vs   = vid_b.vsync_o;
    for (int c = 0; c < 3 * 56 * 2 + 6; c++) begin
      ce_b = (c % 3 == 0);
      @(posedge clk);
      if (ce_b) b_adv();
      #1;
      check_b();
      if (vid_b.vsync_o !== prev_vs) begin
        check("b_vsync_edge_x", 32'(vid_b.x_o), 32'd0);
      end
      prev_vs = vid_b.vsync_o;
      if (vid_b.sof_o && !prev_sof) begin
        if (last_rise >= 0) begin
          check("b_sof_period", 32'(c - last_rise), 32'd168);
          check("b_sol_per_frame", 32'(sol_en), 32'd7);
          check("b_de_per_frame",  32'(de_en),  32'd12);
        end
        last_rise = c;
        sol_en    = 0;
        de_en     = 0;
      end
      prev_sof = vid_b.sof_o;
      if (ce_b && vid_b.sol_o) sol_en++;
      if (ce_b && vid_b.de_o) de_en++;
    end
    check("b_sof_seen", (last_rise == 336) ? 1 : 0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator: one pixel-clock domain producing horizontal and vertical counters, active-pixel coordinates, sync pulses with configurable polarity, data-enable and frame/line markers for LCD/VGA panels. Replaces the per-line vertical counter clocked from hsync. Both axes advance on the pixel clock, qualified by a clock enable. Sits between the PLL/clock divider and the pixel-source / framebuffer read logic.

## Interface
- CW, 12: counter and coordinate width.
- HACTIVE, 480: active pixels per line.
- HFP, 8: horizontal front porch, pixels.
- HSYNC, 4: hsync pulse width, pixels.
- HBP, 43: horizontal back porch, pixels.
- VACTIVE, 272: active lines per frame.
- VFP, 4: vertical front porch, lines.
- VSYNC, 10: vsync pulse width, lines.
- VBP, 2: vertical back porch, lines.
- HPOL, 0: hsync active level (0 = active-low).
- VPOL, 0: vsync active level.

Ports:
- clk_i  in  1  pixel clock.
- rst_n_i  in  1  asynchronous reset, active-low.
- ce_i  in  1  pixel enable; all state advances only when high.
- hsync_o  out  1  horizontal sync, level per HPOL.
- vsync_o  out  1  vertical sync, level per VPOL.
- de_o  out  1  high when both axes are in the active region.
- x_o  out  CW  horizontal counter, 0..HTOTAL-1.
- y_o  out  CW  vertical counter, 0..VTOTAL-1.
- sol_o  out  1  one-cycle pulse on x_o == 0.
- sof_o  out  1  one-cycle pulse on x_o == 0 and y_o == 0.

## Operation
- HTOTAL = HACTIVE+HFP+HSYNC+HBP, VTOTAL = VACTIVE+VFP+VSYNC+VBP.
- Region order per axis: active [0, ACTIVE-1], front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC-1], back porch.
- On ce_i: x increments; at HTOTAL-1 wraps to 0 and y increments; y wraps from VTOTAL-1 to 0 on the same edge x wraps.
- ce_i low: every output holds, including sol_o/sof_o; pulses last exactly one enabled cycle.
- de_o = (x < HACTIVE) and (y < VACTIVE).
- hsync_o asserted exactly HSYNC pixels per line; vsync_o asserted exactly VSYNC whole lines, with edges coinciding with x wrapping to 0.
- Elaboration error if any of HACTIVE, HFP, HSYNC, HBP, VACTIVE, VFP, VSYNC, VBP is 0, or HTOTAL or VTOTAL exceeds 2^CW.

## Timing
- All outputs registered; no combinational path from input to output.
- Sync, de_o, sol_o and sof_o are computed from next-state counters in the same register stage as x_o/y_o, giving zero skew: every output describes the pixel at (x_o, y_o).
- Reset (async assert, sync release): x_o = HTOTAL-1, y_o = VTOTAL-1, de_o = 0, sol_o = sof_o = 0, hsync_o = ~HPOL, vsync_o = ~VPOL (last back-porch pixel).
- First enabled edge after reset: x_o = y_o = 0, de_o = 1, sol_o = sof_o = 1.
- Reset mid-frame returns to the reset state immediately, without completing the line.

## Configuration
- VTG_LOOKAHEAD_EN defined: extra outputs nx_o, ny_o (CW each) and nde_o, registered, describing the pixel one enabled cycle ahead of x_o/y_o, including across line and frame wrap. They cover one cycle of framebuffer/ROM read latency. Reset values: nx_o = 0, ny_o = 0, nde_o = 1.
- Not defined: those ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package vtg_pkg: default 480x272 timing constants, a total-computation function, and region-decode helper functions (in_active, in_sync).
- One sub-module, vtg_axis: a single-axis counter with wrap pulse, active and sync decode, parametrised by ACTIVE/FP/SYNC/BP/POL. It is instantiated twice, the vertical instance stepped by the horizontal wrap.

## Test plan
- Defaults, ce_i tied high, run 2 frames -> period 535x288 = 154080 cycles between sof_o pulses; 272x480 de_o cycles per frame.
- Line check -> hsync_o low for x in 488..491 only (4 cycles); vsync_o low for y in 276..285 (exactly 10 lines), edges at x = 0.
- Reset release -> x_o = 534, y_o = 287, all syncs high, de_o = 0; first edge gives (0,0), sof_o = 1, de_o = 1.
- ce_i toggled 1-of-3 -> outputs hold during ce_i = 0; sof_o period is 3x154080 cycles; sol_o high 1 enabled cycle per line.
- HPOL = VPOL = 1, CW = 10, minimal porches of 1 -> sync polarity inverted; the wrap at x = HTOTAL-1 is correct.
- VTG_LOOKAHEAD_EN -> nx_o/ny_o equal the next cycle's x_o/y_o for every enabled cycle, including (534,287) -> (0,0).
